// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx - UART receiver for 8N1 serial frames (LSB first) on the 50 MHz clock.
//
// Ports:
//   clk_50m   in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   rxd       in   serial line, idle high, asynchronous to clk_50m
//   rx_data   out  [7:0] last good received byte
//   rx_valid  out  one-cycle pulse, rx_data holds a new good byte
//   frame_err out  one-cycle pulse, stop bit (or parity) was bad
//   rx_busy   out  high while a frame is in progress
//
// Optional feature: define UART_RX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (8E1 framing).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_DIV_M1  = CNT_W'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        ,S_PARITY = 3'd4
`endif
    } state_e;

`ifdef UART_RX_PARITY_EN
    // Even parity over the received byte: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [7:0]       shreg_q,     shreg_d;
    logic [1:0]       sync_q,      sync_d;
    logic             rxd_d_q,     rxd_d_d;
    logic [7:0]       rx_data_q,   rx_data_d;
    logic             rx_valid_q,  rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_busy_q,   rx_busy_d;
`ifdef UART_RX_PARITY_EN
    logic             par_err_q,   par_err_d;
`endif
    logic             rxd_s;
    logic             stop_ok_s;

    // Second synchronizer stage is the metastability-safe view of the line.
    assign rxd_s = sync_q[1];

    // Next-state, datapath and output computation.
    always_comb begin
        sync_d      = {sync_q[0], rxd};
        rxd_d_d     = rxd_s;
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d   = par_err_q;
        stop_ok_s   = rxd_s & ~par_err_q;
`else
        stop_ok_s   = rxd_s;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // Only a true 1->0 transition starts a frame, so a held-low line never retriggers.
                if (rxd_d_q && !rxd_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF_M1) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                        par_err_d = 1'b0;
`endif
                    end else begin
                        // Line back high at mid-start: treat as a glitch.
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_DIV_M1) begin
                    cnt_d            = '0;
                    shreg_d[bit_idx_q] = rxd_s;
                    bit_idx_d        = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_DIV_M1) begin
                    cnt_d     = '0;
                    par_err_d = rxd_s ^ even_parity(shreg_q);
                    state_d   = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                if (cnt_q == CNT_DIV_M1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (stop_ok_s) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        rx_busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers; synchronizer presets to the idle level.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'h00;
            sync_q      <= 2'b11;
            rxd_d_q     <= 1'b1;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            sync_q      <= sync_d;
            rxd_d_q     <= rxd_d_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx - self-checking bench for uart_rx. A table of frames is driven on
// rxd; each frame pushes its expected outcome to a scoreboard queue that a
// monitor pops whenever rx_valid or frame_err pulses. Hand-written sequences
// cover glitch, break, mid-frame reset and (with UART_RX_PARITY_EN) parity.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int DIV    = 434;
    localparam int HALF   = 217;
    localparam int BIT_NS = DIV * 20;
`ifdef UART_RX_PARITY_EN
    localparam int BITS_AFTER_START = 10;
`else
    localparam int BITS_AFTER_START = 9;
`endif
    localparam int BUSY_CYCLES = HALF + BITS_AFTER_START * DIV;
    localparam int SPACING     = (BITS_AFTER_START + 1) * DIV;

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    always #10 clk_50m = ~clk_50m;

    uart_rx dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap_bits;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } sb_t;

    sb_t        sb[$];
    longint     valid_cyc[$];
    sb_t        mon_e;
    int         errors   = 0;
    int         checks   = 0;
    longint     cyc      = 0;
    longint     busy_cnt = 0;
    logic [7:0] last_good = 8'h00;
    vec_t       vecs[6];
    longint     b0;

    always @(posedge clk_50m) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input longint act, input longint exp, input longint tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // Reference model of the outcome of one frame.
    task automatic expect_frame(input logic [7:0] d, input logic good);
        if (good) begin
            last_good = d;
            sb.push_back('{1'b0, d});
        end else begin
            sb.push_back('{1'b1, last_good});
        end
    endtask

    task automatic send_data(input logic [7:0] d);
        rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            #(BIT_NS);
        end
    endtask

    // Drives one frame with correct parity (when enabled); rxd is left at the stop level.
    task automatic send(input logic [7:0] d, input logic stop);
        send_data(d);
`ifdef UART_RX_PARITY_EN
        rxd = ^d;
        #(BIT_NS);
`endif
        rxd = stop;
        #(BIT_NS);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_par(input logic [7:0] d, input logic par, input logic stop);
        send_data(d);
        rxd = par;
        #(BIT_NS);
        rxd = stop;
        #(BIT_NS);
    endtask
`endif

    task automatic drain();
        for (int i = 0; i < 3 * DIV && sb.size() != 0; i++) #20;
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b1, 2, 1'b0, 8'h55};
        vecs[1] = '{8'hA3, 1'b1, 0, 1'b0, 8'hA3};
        vecs[2] = '{8'h0F, 1'b1, 2, 1'b0, 8'h0F};
        vecs[3] = '{8'h00, 1'b1, 1, 1'b0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 1, 1'b0, 8'hFF};
        vecs[5] = '{8'hC5, 1'b0, 2, 1'b1, 8'hFF};

        rst_n = 1'b1;
        rxd   = 1'b1;
        #5;
        rst_n = 1'b0;

        fork
            forever begin
                @(negedge clk_50m);
                if (rx_busy) busy_cnt++;
                if (rx_valid || frame_err) begin
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", {30'd0, rx_valid, frame_err}, 32'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("frame_result", {22'd0, rx_valid, frame_err, rx_data},
                              {22'd0, ~mon_e.err, mon_e.err, mon_e.data});
                    end
                    if (rx_valid) valid_cyc.push_back(cyc);
                end
            end
        join_none

        #90;
        check("reset_outputs", {21'd0, rx_data, rx_valid, frame_err, rx_busy}, 32'd0);
        rst_n = 1'b1;
        #(2 * BIT_NS);
        check("idle_after_reset", {21'd0, rx_data, rx_valid, frame_err, rx_busy}, 32'd0);

        // Table-driven frames, including a back-to-back pair and a bad stop bit.
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{vecs[i].exp_err, vecs[i].exp_data});
            if (!vecs[i].exp_err) last_good = vecs[i].exp_data;
            b0 = busy_cnt;
            send(vecs[i].data, vecs[i].stop);
            check_near($sformatf("busy_len_%0d", i), busy_cnt - b0, BUSY_CYCLES, 2);
            rxd = 1'b1;
            if (vecs[i].gap_bits > 0) #(vecs[i].gap_bits * BIT_NS);
        end
        drain();
        if (valid_cyc.size() >= 3) begin
            check_near("b2b_spacing", valid_cyc[2] - valid_cyc[1], SPACING, 2);
        end else begin
            check("b2b_pulses", valid_cyc.size(), 3);
        end

        // Short low glitch on an idle line: aborted in START, nothing reported.
        rxd = 1'b0;
        #1000;
        check("glitch_busy", {31'd0, rx_busy}, 32'd1);
        #1000;
        rxd = 1'b1;
        #(2 * BIT_NS);
        check("glitch_idle", {31'd0, rx_busy}, 32'd0);
        expect_frame(8'h3C, 1'b1);
        send(8'h3C, 1'b1);
        rxd = 1'b1;
        #(2 * BIT_NS);

        // Bad stop bit followed by a break: one frame_err, no retrigger while low.
        expect_frame(8'hF0, 1'b0);
        send(8'hF0, 1'b0);
        #(5 * BIT_NS);
        check("break_no_retrigger", {31'd0, rx_busy}, 32'd0);
        check("break_data_kept", {24'd0, rx_data}, 32'h3C);
        rxd = 1'b1;
        #(2 * BIT_NS);
        drain();

        // Async reset during data bit 4 of 0x81 discards the frame.
        send_data_partial: begin
            logic [7:0] d;
            d = 8'h81;
            rxd = 1'b0;
            #(BIT_NS);
            for (int i = 0; i < 4; i++) begin
                rxd = d[i];
                #(BIT_NS);
            end
            rxd = d[4];
            #(BIT_NS / 2);
        end
        check("midframe_busy", {31'd0, rx_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {21'd0, rx_data, rx_valid, frame_err, rx_busy}, 32'd0);
        rxd = 1'b1;
        #(BIT_NS);
        rst_n = 1'b1;
        last_good = 8'h00;
        #(2 * BIT_NS);
        check("post_reset_idle", {31'd0, rx_busy}, 32'd0);
        expect_frame(8'h7E, 1'b1);
        send(8'h7E, 1'b1);
        rxd = 1'b1;
        #(2 * BIT_NS);
        check("post_reset_data", {24'd0, rx_data}, 32'h7E);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1.
        expect_frame(8'h07, 1'b1);
        send_par(8'h07, 1'b1, 1'b1);
        rxd = 1'b1;
        #(2 * BIT_NS);
        expect_frame(8'h07, 1'b0);
        send_par(8'h07, 1'b0, 1'b1);
        rxd = 1'b1;
        #(2 * BIT_NS);
        check("parity_data_kept", {24'd0, rx_data}, 32'h07);
`endif

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
